// File: rtl/fetch_stall_unit_if.sv
// fetch_stall_unit_if: bundles the hazard, branch, fetch and pipeline-register
// signals of fetch_stall_unit.
//   master : drives hazard enables, branch redirect, imem_instr, ctrl_in;
//            observes PC, IF/ID, ID/EX, pipe_state, stall_count.
//   slave  : the fetch_stall_unit side (mirror of master).
interface fetch_stall_unit_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned CTRL_W = 8
);
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 32;

  // hazard unit / EX stage / fetch / decode inputs
  logic                enable_PCWrite;
  logic                enable_Write;
  logic                mux_out;
  logic                branch_taken;
  logic [XLEN-1:0]     branch_target;
  logic [INSTR_W-1:0]  imem_instr;
  logic [CTRL_W-1:0]   ctrl_in;

  // registered pipeline state
  logic [XLEN-1:0]     pc_out;
  logic [XLEN-1:0]     ifid_pc;
  logic [INSTR_W-1:0]  ifid_instr;
  logic                ifid_valid;
  logic [CTRL_W-1:0]   idex_ctrl;
  logic                idex_valid;
  logic [1:0]          pipe_state;
  logic [CNT_W-1:0]    stall_count;

  modport master (
    output enable_PCWrite, enable_Write, mux_out, branch_taken, branch_target,
           imem_instr, ctrl_in,
    input  pc_out, ifid_pc, ifid_instr, ifid_valid, idex_ctrl, idex_valid,
           pipe_state, stall_count
  );

  modport slave (
    input  enable_PCWrite, enable_Write, mux_out, branch_taken, branch_target,
           imem_instr, ctrl_in,
    output pc_out, ifid_pc, ifid_instr, ifid_valid, idex_ctrl, idex_valid,
           pipe_state, stall_count
  );
endinterface

// File: rtl/fetch_stall_unit.sv
// fetch_stall_unit: owns the PC, the IF/ID register and the control half of
// ID/EX. Applies load-use stalls (hold PC and IF/ID, bubble ID/EX) and flushes
// on EX-stage taken branches.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : fetch_stall_unit_if.slave (hazard enables, branch redirect,
//              imem_instr, ctrl_in in; pc_out, IF/ID, ID/EX, pipe_state,
//              stall_count out; all outputs registered)
// Optional feature: define STALL_PERF_CNT_EN to build the saturating stall
// counter; otherwise stall_count is tied to 0.
module fetch_stall_unit #(
  parameter int unsigned    XLEN      = 64,
  parameter int unsigned    CTRL_W    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]    NOP_INSTR = 32'h0000_0013
) (
  input logic               clk,
  input logic               reset_n,
  fetch_stall_unit_if.slave bus
);
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state_q;
  logic [XLEN-1:0]     pc_q;
  logic [XLEN-1:0]     ifid_pc_q;
  logic [INSTR_W-1:0]  ifid_instr_q;
  logic                ifid_valid_q;
  logic [CTRL_W-1:0]   idex_ctrl_q;
  logic                idex_valid_q;

  // Any single deasserted enable is a full stall so PC and IF/ID never split.
  logic stall_c;
  assign stall_c = ~bus.enable_PCWrite | ~bus.enable_Write | ~bus.mux_out;

  // Pipeline registers and state; priority reset > branch > stall > advance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      idex_ctrl_q  <= '0;
      idex_valid_q <= 1'b0;
    end else if (bus.branch_taken) begin
      state_q      <= ST_FLUSH;
      pc_q         <= bus.branch_target;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      idex_ctrl_q  <= '0;
      idex_valid_q <= 1'b0;
    end else if (stall_c) begin
      state_q      <= ST_STALL;
      idex_ctrl_q  <= '0;
      idex_valid_q <= 1'b0;
    end else begin
      state_q      <= ST_RUN;
      pc_q         <= pc_q + XLEN'(4);
      ifid_pc_q    <= pc_q;
      ifid_instr_q <= bus.imem_instr;
      ifid_valid_q <= 1'b1;
      idex_ctrl_q  <= bus.ctrl_in;
      idex_valid_q <= ifid_valid_q;
    end
  end

  assign bus.pc_out     = pc_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.idex_ctrl  = idex_ctrl_q;
  assign bus.idex_valid = idex_valid_q;
  assign bus.pipe_state = state_q;

`ifdef STALL_PERF_CNT_EN
  localparam int unsigned CNT_W = 32;
  logic [CNT_W-1:0] stall_cnt_q;

  // Counts applied stalls only (a branch overrides the stall); saturates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (!bus.branch_taken && stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = '0;
`endif
endmodule

// File: doc/fetch_stall_unit.md
# fetch_stall_unit

Sequential consumer of the load-use stall signals (`mux_out`, `enable_Write`, `enable_PCWrite`) produced by the hazard detection unit. It owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register. It applies stalls by holding PC and IF/ID, inserting a bubble into ID/EX, and flushing on taken branches. It sits between instruction memory, the decoder/control unit and the execute stage of the 5-stage RISC-V pipeline.

## Interface
- `XLEN`, 64, PC/address width
- `CTRL_W`, 8, width of decoded control bundle
- `RESET_PC`, 0, PC value loaded at reset
- `NOP_INSTR`, 32'h00000013, instruction injected on flush/reset (addi x0,x0,0)

- `clk` in 1: single clock, rising edge
- `reset_n` in 1: synchronous, active-low reset
- `enable_PCWrite` in 1: 1 = PC may advance
- `enable_Write` in 1: 1 = IF/ID may load
- `mux_out` in 1: 1 = pass control, 0 = bubble into ID/EX
- `branch_taken` in 1: EX-stage taken branch/jump
- `branch_target` in XLEN: redirect address
- `imem_instr` in 32: instruction at `pc_out` (combinational memory)
- `ctrl_in` in CTRL_W: decoded control for instruction in IF/ID
- `pc_out` out XLEN: current fetch PC
- `ifid_pc` out XLEN, `ifid_instr` out 32, `ifid_valid` out 1: IF/ID register
- `idex_ctrl` out CTRL_W, `idex_valid` out 1: ID/EX control register
- `pipe_state` out 2: 0 RUN, 1 STALL, 2 FLUSH
- `stall_count` out 32: only with STALL_PERF_CNT_EN

## Operation
- Stall condition `stall = ~enable_PCWrite | ~enable_Write | ~mux_out`. Any single deasserted enable is treated as a full stall. PC and IF/ID hold together; never partial.
- Priority per cycle: reset > branch_taken > stall > normal advance.
- Normal (RUN): `pc_out <= pc_out + 4`; IF/ID <= {pc_out, imem_instr, 1}; `idex_ctrl <= ctrl_in`; `idex_valid <= ifid_valid`.
- Stall: PC and IF/ID hold; `idex_ctrl <= 0`; `idex_valid <= 0`.
- branch_taken: `pc_out <= branch_target`; IF/ID <= {0, NOP_INSTR, 0}; `idex_ctrl <= 0`, `idex_valid <= 0`. branch_taken overrides a simultaneous stall.
- State machine (registered, drives `pipe_state`):
  - RUN→STALL on stall.
  - Any state→FLUSH on branch_taken.
  - STALL→RUN when stall drops.
  - FLUSH→RUN next cycle if no stall/branch, else →STALL/FLUSH accordingly.
- PC arithmetic is modulo 2^XLEN. `pc_out + 4` wraps from 2^XLEN−4 to 0. `branch_target` is taken verbatim; bits [1:0] are not checked.

## Timing
- All outputs are registered. Inputs are sampled on the rising edge of `clk`. Effects are visible the following cycle.
- Reset values: `pc_out`=RESET_PC, `ifid_pc`=0, `ifid_instr`=NOP_INSTR, `ifid_valid`=0, `idex_ctrl`=0, `idex_valid`=0, `pipe_state`=RUN, `stall_count`=0.
- Stall latency: hazard asserted in cycle N → PC/IF/ID unchanged at N+1, bubble in ID/EX at N+1.
- Each cycle of stall holds one cycle. There is no stall cap.
- Branch redirect: `branch_target` appears on `pc_out` one cycle later. The first valid IF/ID from the target appears two cycles later.
- Reset asserted mid-stall or mid-flush returns all outputs to reset values at the next edge, regardless of other inputs.

## Configuration
- `STALL_PERF_CNT_EN` defined:
  - `stall_count` increments by 1 on each edge where stall is applied (branch_taken=0, stall=1).
  - It saturates at 32'hFFFFFFFF.
  - It clears on reset.
- Not defined: `stall_count` is driven constant 0 and no counter register is built.

## Test plan
- Reset: hold `reset_n`=0 two cycles with random inputs → `pc_out`=RESET_PC, `ifid_instr`=32'h00000013, both valids 0, `pipe_state`=0.
- Free run: all enables 1, instr=32'h00500093 for 3 cycles from PC 0 → `pc_out` 0,4,8,12; `ifid_pc`=8 with `ifid_valid`=1; `idex_ctrl` tracks `ctrl_in`.
- Load-use stall: all three enables 0 for 1 cycle at `pc_out`=8 → `pc_out` stays 8, `ifid` unchanged, `idex_ctrl`=0, `idex_valid`=0, `pipe_state`=1. Resumes to 12 next cycle.
- Partial enable: only `enable_PCWrite`=0 → treated as full stall, identical outputs to previous scenario.
- Branch during stall: stall=1 and branch_taken=1, target=0x100 → `pc_out`=0x100, `ifid_valid`=0, `pipe_state`=2. Next cycle `pc_out`=0x104, `pipe_state`=0.
- Wrap and counter: `pc_out`=2^XLEN−4 with all enables 1 → `pc_out`=0. With STALL_PERF_CNT_EN, 5 stall cycles → `stall_count`=5. Reset mid-stall → `stall_count`=0.
